// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Optional seven-segment decode of the result is enabled by defining BIN2BCD_SEG_EN.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
`ifdef BIN2BCD_SEG_EN
  ,
  output logic [7*DIGITS-1:0]   seg
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam longint DEC_RANGE = 64'(10) ** DIGITS;
  localparam longint BIN_RANGE = 64'(1) << WIDTH;

  generate
    if (DEC_RANGE < BIN_RANGE) begin : g_digits_check
      $error("bin2bcd_seq: DIGITS too small to represent 2**WIDTH-1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state, state_next;
  logic [WIDTH-1:0]    shreg, shreg_next;
  logic [4*DIGITS-1:0] scratch, scratch_next, adj;
  logic [CW-1:0]       cnt, cnt_next;

  // Per-digit correction; each digit wraps on its own, no carry into the next.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (scratch[4*gi +: 4] >= 4'd5) ?
                              scratch[4*gi +: 4] + 4'd3 : scratch[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    scratch_next = scratch;
    cnt_next     = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          shreg_next   = bin;
          scratch_next = '0;
          cnt_next     = CW'(WIDTH - 1);
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_next, shreg_next} = {adj, shreg} << 1;
        if (cnt == '0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      bcd     <= '0;
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      scratch <= scratch_next;
      cnt     <= cnt_next;
      done    <= (state == DONE);
      if (state == DONE) begin
        bcd <= scratch;
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef BIN2BCD_SEG_EN
  logic [7*DIGITS-1:0] seg_dec;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'h3F;
      4'd1:    seg_of = 7'h06;
      4'd2:    seg_of = 7'h5B;
      4'd3:    seg_of = 7'h4F;
      4'd4:    seg_of = 7'h66;
      4'd5:    seg_of = 7'h6D;
      4'd6:    seg_of = 7'h7D;
      4'd7:    seg_of = 7'h07;
      4'd8:    seg_of = 7'h7F;
      4'd9:    seg_of = 7'h6F;
      default: seg_of = 7'h00;
    endcase
  endfunction

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_seg
      assign seg_dec[7*gi +: 7] = seg_of(scratch[4*gi +: 4]);
    end
  endgenerate

  // Latched alongside bcd so both always describe the same result.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= '0;
    end else if (state == DONE) begin
      seg <= seg_dec;
    end
  end
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: driver queues sampled values, monitor checks each done.
// Seven-segment checks are compiled in when BIN2BCD_SEG_EN is defined.
module tb_bin2bcd_seq;
  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic                clk = 1'b0;
  logic                rst, start;
  logic [WIDTH-1:0]    bin;
  logic                busy, done;
  logic [4*DIGITS-1:0] bcd;
`ifdef BIN2BCD_SEG_EN
  logic [7*DIGITS-1:0] seg;
`endif

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd)
`ifdef BIN2BCD_SEG_EN
    , .seg(seg)
`endif
  );

  always #5 clk = ~clk;

  // Reference: plain decimal digit extraction.
  function automatic logic [4*DIGITS-1:0] ref_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

`ifdef BIN2BCD_SEG_EN
  function automatic logic [7*DIGITS-1:0] ref_seg(input int v);
    logic [6:0] tbl [10];
    logic [7*DIGITS-1:0] r;
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      r[7*d +: 7] = tbl[v % 10];
      v = v / 10;
    end
    return r;
  endfunction
`endif

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse consumes one expected value.
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: actual bcd=%h required no done", bcd);
      end else begin
        int v;
        v = exp_q.pop_front();
        if (bcd !== ref_bcd(v)) begin
          errors++;
          $display("FAIL bcd bin=%0d: actual=%h required=%h", v, bcd, ref_bcd(v));
        end else begin
          $display("conv bin=%0d bcd=%h", v, bcd);
        end
`ifdef BIN2BCD_SEG_EN
        checks++;
        if (seg !== ref_seg(v)) begin
          errors++;
          $display("FAIL seg bin=%0d: actual=%h required=%h", v, seg, ref_seg(v));
        end
`endif
      end
    end
  end

  // One conversion with latency and busy-window checks; optionally a second
  // start during busy (ignored) or a reset mid-conversion (aborts).
  task automatic convert(input int v, input int late_start, input int abort_at);
    int busy_cnt, lat;
    @(negedge clk);
    bin = WIDTH'(v); start = 1'b1;
    if (abort_at < 0) exp_q.push_back(v);
    @(negedge clk);
    start = 1'b0;
    bin = WIDTH'($urandom);
    busy_cnt = 0; lat = -1;
    for (int j = 0; j < 30; j++) begin
      if (j > 0) @(negedge clk);
      if (abort_at >= 0 && j == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_bcd", int'(bcd), 0);
        repeat (15) @(negedge clk);
        return;
      end
      if (late_start >= 0 && j == late_start) begin
        start = 1'b1; bin = WIDTH'(7);
      end else begin
        start = 1'b0;
      end
      if (busy) busy_cnt++;
      if (done) begin
        lat = j;
        break;
      end
    end
    start = 1'b0;
    check("latency", lat, WIDTH + 1);
    check("busy_cycles", busy_cnt, WIDTH + 1);
    check("busy_after_done", int'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; bin = 8'd55;
    repeat (2) @(negedge clk);
    check("reset_busy_during", int'(busy), 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_bcd", int'(bcd), 0);

    convert(0, -1, -1);
    convert(255, -1, -1);
    convert(99, -1, -1);
    convert(100, -1, -1);
    convert(138, -1, -1);
    convert(42, 2, -1);
    repeat (15) @(negedge clk);
    convert(200, -1, 3);
    for (int i = 0; i < 25; i++) convert(int'($urandom_range(0, 255)), -1, -1);

    // Start held high with an incrementing count: one acceptance every WIDTH+2 edges.
    begin
      int base, dones;
      base = int'($urandom_range(0, 200));
      dones = 0;
      for (int c = 0; c < 5 * (WIDTH + 2); c++) begin
        @(negedge clk);
        if (c > 0 && done) dones++;
        start = 1'b1;
        bin = WIDTH'(base + c);
        if (c % (WIDTH + 2) == 0) exp_q.push_back((base + c) % 256);
      end
      @(negedge clk);
      if (done) dones++;
      start = 1'b0;
      repeat (15) @(negedge clk);
      check("b2b_done_count", dones, 5);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
